// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave bridging command/address/data(/mask) frames onto a register map.
// All SPI inputs are oversampled on clk; sclk edges are detected after synchronization.
module spi_reg_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       enable,
  input  logic       csb,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       reg_wr,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wdat,
  output logic [7:0] reg_mask,
  output logic [7:0] reg_rd_addr_a,
  input  logic [7:0] reg_rdat_a,
  output logic       frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, MASK, WAIT} state_t;

  state_t                 state, nstate;
  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, mosi_sync, settle;
  logic                   sclk_d, csb_s, sclk_s, mosi_s, sclk_rise, sclk_fall;
  logic                   armed;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_sh, rx_next, addr_q, data_q, tx_sh;
  logic                   cmd_rd, cmd_mask;
  logic                   byte_done, cmd_err, wr_fire, rd_load, rd_cap, tx_on;
  logic                   miso_q, oe_q;

  // Input synchronizers; settle marks when every stage holds a real sample after reset
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      csb_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      settle    <= '0;
      sclk_d    <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
    end
  end

  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // A frame may only start after csb has been seen high, so a frame cut by reset
  // or by enable is never resumed half-way.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                       armed <= 1'b0;
    else if (!settle[SYNC_STAGES-1])  armed <= 1'b0;
    else if (csb_s)                   armed <= 1'b1;
    else if (!enable || state == CMD) armed <= 1'b0;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= nstate;
  end

  // FSM: next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (armed && !csb_s) nstate = CMD;
      CMD:     if (byte_done) nstate = cmd_err ? WAIT : ADDR;
      ADDR:    if (byte_done) nstate = DATA;
      DATA:    if (byte_done) nstate = cmd_mask ? MASK : WAIT;
      MASK:    if (byte_done) nstate = WAIT;
      WAIT:    nstate = WAIT;
      default: nstate = IDLE;
    endcase
    if (!enable || csb_s) nstate = IDLE;
  end

  // FSM: decoded strobes
  always_comb begin
    rx_next   = {rx_sh[6:0], mosi_s};
    byte_done = 1'b0;
    if (enable && !csb_s && sclk_rise && bit_cnt == 3'd7) begin
      case (state)
        CMD, ADDR, DATA, MASK: byte_done = 1'b1;
        default:               byte_done = 1'b0;
      endcase
    end
    cmd_err = byte_done && state == CMD &&
              (rx_next[5:0] != 6'd0 || rx_next[7:6] == 2'b11);
    wr_fire = byte_done && ((state == DATA && !cmd_rd && !cmd_mask) || state == MASK);
    rd_load = byte_done && state == ADDR && cmd_rd;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bit_cnt       <= 3'd0;
      rx_sh         <= 8'h00;
      cmd_rd        <= 1'b0;
      cmd_mask      <= 1'b0;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      reg_wr        <= 1'b0;
      reg_wr_addr   <= 8'h00;
      reg_wdat      <= 8'h00;
      reg_mask      <= 8'h00;
      reg_rd_addr_a <= 8'h00;
      frame_err     <= 1'b0;
      rd_cap        <= 1'b0;
    end else begin
      reg_wr    <= wr_fire;
      frame_err <= cmd_err;
      rd_cap    <= rd_load;
      if (state == IDLE || state == WAIT) bit_cnt <= 3'd0;
      else if (sclk_rise)                 bit_cnt <= bit_cnt + 3'd1;
      if (sclk_rise) rx_sh <= rx_next;
      if (byte_done) begin
        case (state)
          CMD:     {cmd_rd, cmd_mask} <= rx_next[7:6];
          ADDR:    addr_q <= rx_next;
          DATA:    data_q <= rx_next;
          default: ;
        endcase
      end
      if (rd_load) reg_rd_addr_a <= rx_next;
      if (wr_fire) begin
        reg_wr_addr <= addr_q;
        if (state == MASK) begin
          reg_wdat <= data_q;
          reg_mask <= rx_next;
        end else begin
          reg_wdat <= rx_next;
          reg_mask <= 8'h00;
        end
      end
    end
  end

  // Read path: the capture lands before the 8th address fall, which then presents bit 7
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tx_sh  <= 8'h00;
      tx_on  <= 1'b0;
      miso_q <= 1'b0;
      oe_q   <= 1'b0;
    end else if (state == IDLE || !enable) begin
      tx_on  <= 1'b0;
      miso_q <= 1'b0;
      oe_q   <= 1'b0;
    end else if (rd_cap) begin
      tx_sh <= reg_rdat_a;
      tx_on <= 1'b1;
    end else if (tx_on && sclk_fall) begin
      miso_q <= tx_sh[7];
      oe_q   <= 1'b1;
      tx_sh  <= {tx_sh[6:0], 1'b0};
    end
  end

  assign miso_oe = oe_q & enable;
  assign miso    = miso_q & miso_oe;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: write, masked write, read, abort, bad command, reset, disable.
module tb_spi_reg_slave;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_l, enable, csb, sclk, mosi;
  logic       miso, miso_oe, reg_wr, frame_err;
  logic [7:0] reg_wr_addr, reg_wdat, reg_mask, reg_rd_addr_a, reg_rdat_a;

  int tests = 0, fails = 0;
  int wr_pulses = 0, wr_cycles = 0, ferr_pulses = 0, ferr_cycles = 0, oe_cycles = 0;
  logic       wr_q = 1'b0, ferr_q = 1'b0;
  logic [7:0] cap_addr = 8'h00, cap_wdat = 8'h00, cap_mask = 8'h00;
  logic [7:0] rd_byte;
  int b_wr, b_wc, b_fp, b_fc, b_oe;

  spi_reg_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_l(rst_l), .enable(enable), .csb(csb), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
    .reg_wdat(reg_wdat), .reg_mask(reg_mask), .reg_rd_addr_a(reg_rd_addr_a),
    .reg_rdat_a(reg_rdat_a), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register map model: only 0xE1 holds a non-zero value
  assign reg_rdat_a = (reg_rd_addr_a == 8'hE1) ? 8'hA5 : 8'h00;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cycles <= wr_cycles + 1;
      cap_addr  <= reg_wr_addr;
      cap_wdat  <= reg_wdat;
      cap_mask  <= reg_mask;
      if (!wr_q) wr_pulses <= wr_pulses + 1;
    end
    if (frame_err) begin
      ferr_cycles <= ferr_cycles + 1;
      if (!ferr_q) ferr_pulses <= ferr_pulses + 1;
    end
    if (miso_oe) oe_cycles <= oe_cycles + 1;
    wr_q   <= reg_wr;
    ferr_q <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_wr = wr_pulses; b_wc = wr_cycles; b_fp = ferr_pulses; b_fc = ferr_cycles; b_oe = oe_cycles;
  endtask

  // Master samples miso just before each rise; mosi changes while sclk is low
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      wait_clk(HALF);
      rx   = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    csb = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_hi();
    wait_clk(6);
    csb = 1'b1;
    wait_clk(12);
  endtask

  task automatic spi_frame(input logic [31:0] w, input int nbytes);
    logic [7:0] rx;
    cs_lo();
    for (int k = 0; k < nbytes; k++) begin
      spi_bits(w[31-8*k -: 8], 8, rx);
      if (k == 2) rd_byte = rx;
    end
    cs_hi();
  endtask

  initial begin
    logic [7:0] rx;
    rst_l = 1'b0; enable = 1'b1; csb = 1'b1; sclk = 1'b0; mosi = 1'b0; rd_byte = 8'h00;
    wait_clk(4);
    check("rst_reg_wr",  {31'd0, reg_wr}, 32'd0);
    check("rst_addr",    {24'd0, reg_wr_addr}, 32'd0);
    check("rst_miso_oe", {30'd0, miso, miso_oe}, 32'd0);
    check("rst_ferr",    {31'd0, frame_err}, 32'd0);
    rst_l = 1'b1;
    wait_clk(10);

    // Plain write 00 48 15
    snap();
    spi_frame(32'h00481500, 3);
    check("wr_pulses",   wr_pulses - b_wr, 1);
    check("wr_cycles",   wr_cycles - b_wc, 1);
    check("wr_addr",     cap_addr, 8'h48);
    check("wr_wdat",     cap_wdat, 8'h15);
    check("wr_mask",     cap_mask, 8'h00);
    check("wr_no_ferr",  ferr_pulses - b_fp, 0);

    // Masked write 40 E0 FF 07
    snap();
    spi_frame(32'h40E0FF07, 4);
    check("mwr_cycles",  wr_cycles - b_wc, 1);
    check("mwr_addr",    cap_addr, 8'hE0);
    check("mwr_wdat",    cap_wdat, 8'hFF);
    check("mwr_mask",    cap_mask, 8'h07);

    // Read 80 E1 00, kept open to inspect miso_oe before csb rises
    snap();
    cs_lo();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'hE1, 8, rx);
    spi_bits(8'h00, 8, rd_byte);
    wait_clk(6);
    check("rd_oe_open",  {31'd0, miso_oe}, 32'd1);
    check("rd_addr",     reg_rd_addr_a, 8'hE1);
    check("rd_data",     rd_byte, 8'hA5);
    csb = 1'b1;
    wait_clk(12);
    check("rd_oe_closed", {30'd0, miso, miso_oe}, 32'd0);
    check("rd_no_wr",    wr_cycles - b_wc, 0);
    check("rd_hold_wdat", reg_wdat, 8'hFF);

    // Aborted write, then the full frame
    snap();
    cs_lo();
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h4A, 8, rx);
    spi_bits(8'h3C, 5, rx);
    cs_hi();
    check("abort_no_wr", wr_cycles - b_wc, 0);
    check("abort_hold_addr", reg_wr_addr, 8'hE0);
    spi_frame(32'h004A3C00, 3);
    check("retry_cycles", wr_cycles - b_wc, 1);
    check("retry_addr",  cap_addr, 8'h4A);
    check("retry_wdat",  cap_wdat, 8'h3C);

    // Illegal command C0 48 00
    snap();
    spi_frame(32'hC0480000, 3);
    check("bad_ferr_pulses", ferr_pulses - b_fp, 1);
    check("bad_ferr_cycles", ferr_cycles - b_fc, 1);
    check("bad_no_wr",   wr_cycles - b_wc, 0);
    check("bad_no_oe",   oe_cycles - b_oe, 0);

    // Reset during the data byte of 00 49 0F; release with csb still low
    snap();
    cs_lo();
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h49, 8, rx);
    spi_bits(8'h0F, 4, rx);
    rst_l = 1'b0;
    wait_clk(3);
    check("mid_rst_addr",  reg_wr_addr, 8'h00);
    check("mid_rst_wdat",  reg_wdat, 8'h00);
    check("mid_rst_rdadr", reg_rd_addr_a, 8'h00);
    check("mid_rst_outs",  {28'd0, reg_wr, frame_err, miso, miso_oe}, 32'd0);
    rst_l = 1'b1;
    wait_clk(5);
    spi_bits(8'hF0, 4, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h48, 8, rx);
    spi_bits(8'h15, 8, rx);
    cs_hi();
    check("mid_rst_no_wr", wr_cycles - b_wc, 0);

    // Disabled block ignores a valid frame
    snap();
    enable = 1'b0;
    spi_frame(32'h00480100, 3);
    check("dis_no_wr",   wr_cycles - b_wc, 0);
    check("dis_wdat",    reg_wdat, 8'h00);
    enable = 1'b1;
    wait_clk(10);

    // Block operates normally after reset and re-enable
    snap();
    spi_frame(32'h0010AA00, 3);
    check("post_cycles", wr_cycles - b_wc, 1);
    check("post_addr",   reg_wr_addr, 8'h10);
    check("post_wdat",   reg_wdat, 8'hAA);
    check("post_mask",   reg_mask, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth for csb, sclk and mosi; legal values are 2 and 3.
REQ-002 clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 rst_l  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  block enable, shared with the register map.
REQ-005 csb  input  1  SPI chip select, active low, asynchronous to clk.
REQ-006 sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-007 mosi  input  1  SPI serial data in, MSB first.
REQ-008 miso  output  1  SPI serial data out, MSB first.
REQ-009 miso_oe  output  1  pad output enable for miso.
REQ-010 reg_wr  output  1  one-cycle register-map write strobe.
REQ-011 reg_wr_addr  output  8  register-map write address.
REQ-012 reg_wdat  output  8  register-map write data.
REQ-013 reg_mask  output  8  register-map write mask; 1 = keep the existing bit.
REQ-014 reg_rd_addr_a  output  8  register-map read port A address.
REQ-015 reg_rdat_a  input  8  register-map read port A data, combinational from reg_rd_addr_a.
REQ-016 frame_err  output  1  one-cycle pulse when an illegal command byte is received.

Function
REQ-017 csb, sclk and mosi SHALL each pass through a SYNC_STAGES flop synchronizer; the rise and fall of sclk SHALL be edge-detected on the synchronized value.
REQ-018 The frame SHALL be: command byte, then address byte, then data byte, then a mask byte for masked writes only; all bytes MSB first.
REQ-019 mosi SHALL be sampled on the detected sclk rise; miso SHALL change only on the detected sclk fall.
REQ-020 Command byte: bit7 = read (1) or write (0); bit6 = masked write; bits 5:0 must be 0.
REQ-021 States SHALL be IDLE, CMD, ADDR, DATA, MASK and WAIT; a 3-bit counter SHALL count bits within each byte.
REQ-022 State transitions:
- IDLE->CMD on synchronized csb low.
- CMD->ADDR after 8 bits.
- ADDR->DATA after 8 bits.
- DATA->MASK after 8 bits when the command is a masked write; otherwise DATA->WAIT.
- MASK->WAIT after 8 bits.
- Any state->IDLE on synchronized csb high.
REQ-023 A command with bits 5:0 nonzero, or with bit7=1 and bit6=1, SHALL pulse frame_err for one cycle after the 8th command bit, go to WAIT, and cause no access.
REQ-024 Unmasked write: in the cycle after the 8th data-bit rise, reg_wr SHALL be 1 for exactly one cycle, with reg_wr_addr = address, reg_wdat = data and reg_mask = 8'h00.
REQ-025 Masked write: reg_wr SHALL pulse for exactly one cycle in the cycle after the 8th mask-bit rise, with reg_mask = received mask.
REQ-026 reg_wr_addr, reg_wdat and reg_mask SHALL hold their values until the next write.
REQ-027 Read: reg_rd_addr_a SHALL load the address in the cycle after the 8th address-bit rise; reg_rdat_a SHALL be captured into the tx shift register one cycle later.
REQ-028 Read data output: bit7 SHALL be driven at the 8th address-bit sclk fall, and the remaining bits on the following falls.
REQ-029 miso_oe SHALL be 1 only from the 8th address-bit fall of a read until csb rises; otherwise miso_oe = 0 and miso = 0.
REQ-030 csb rising before the last bit of a write completes SHALL abort the frame with no reg_wr; extra bits received in WAIT SHALL be ignored.
REQ-031 While enable = 0, the state SHALL be forced to IDLE, no reg_wr or frame_err SHALL be generated, and miso_oe = 0.
REQ-032 Supported timing: the clk frequency SHALL be at least 8x the sclk frequency; csb setup and hold to sclk SHALL each be at least 4 clk cycles.
REQ-033 reg_rd_addr_b SHALL NOT be driven by this block.

Reset
REQ-034 On rst_l low, the following SHALL take their reset values asynchronously:
- state = IDLE, bit counter = 0.
- csb synchronizer = 1; sclk and mosi synchronizers = 0.
- reg_wr = 0, reg_wr_addr = 0, reg_wdat = 0, reg_mask = 0, reg_rd_addr_a = 0.
- miso = 0, miso_oe = 0, frame_err = 0.
REQ-035 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait for a fresh csb fall.

Verification
REQ-036 Frame 00 48 15 -> one reg_wr pulse with addr 0x48, wdat 0x15, mask 0x00.
REQ-037 Frame 40 E0 FF 07 -> one reg_wr pulse with addr 0xE0, wdat 0xFF, mask 0x07.
REQ-038 Frame 80 E1 00 with reg_rdat_a = 0xA5 at 0xE1 -> reg_rd_addr_a = 0xE1; miso shifts 1,0,1,0,0,1,0,1; miso_oe high until csb rises; no reg_wr.
REQ-039 Frame 00 4A, then csb high after 5 data bits -> no reg_wr; the next frame 00 4A 3C writes 0x3C.
REQ-040 Frame C0 48 00 -> one frame_err pulse; no reg_wr; miso_oe stays 0.
REQ-041 rst_l low during the data byte of 00 49 0F -> all outputs at reset values and no reg_wr; with enable = 0, frame 00 48 01 gives no reg_wr.
